// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types, constants and helpers for the sequenced ALU.
// Holds the FSM state type, nibble/BCD constants, the nibble-count helper
// (NIBBLES = WIDTH/4 evaluated per instance) and small flag helpers.
package alu_seq_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ADJ  = 1'b1
  } state_t;

  localparam int unsigned NIBBLE_W = 4;
  localparam logic [3:0]  BCD_NINE = 4'd9;
  localparam logic [3:0]  BCD_SIX  = 4'd6;

  // Number of BCD digits in a WIDTH-bit datapath.
  function automatic int unsigned nibbles(input int unsigned width);
    return width / NIBBLE_W;
  endfunction

  // Signed overflow of an addition from the operand and result sign bits.
  function automatic logic add_overflow(input logic a_msb, input logic b_msb,
                                        input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  // Carry out of bit 3 for the low nibbles plus carry-in.
  function automatic logic nibble_carry(input logic [3:0] a, input logic [3:0] b,
                                        input logic cin);
    logic [4:0] t;
    t = 5'(a) + 5'(b) + 5'(cin);
    return t[4];
  endfunction

endpackage

// File: rtl/alu_seq_bcd_adjust.sv
// alu_seq_bcd_adjust: combinational decimal add/subtract nibble walk.
// Ports:
//   i_a, i_b     WIDTH  captured operands (B already inverted for subtract)
//   i_cin        1      carry into nibble 0
//   i_sub        1      0 = decimal add adjust, 1 = decimal subtract adjust
//   o_result_c   WIDTH  BCD-adjusted result
//   o_acr_c      1      carry out of the top digit
//   o_hc_c       1      carry out of digit 0
module alu_seq_bcd_adjust
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_result_c,
  output logic             o_acr_c,
  output logic             o_hc_c
);

  localparam int unsigned NIBBLES = nibbles(WIDTH);

  logic [4:0] w_s;
  logic [3:0] w_digit;
  logic       w_c;

  // Ripple the decimal carry from digit 0 upward.
  always_comb begin
    w_s        = '0;
    w_digit    = '0;
    w_c        = i_cin;
    o_result_c = '0;
    o_hc_c     = 1'b0;
    for (int k = 0; k < int'(NIBBLES); k++) begin
      w_s = 5'(i_a[k*4 +: 4]) + 5'(i_b[k*4 +: 4]) + 5'(w_c);
      if (!i_sub) begin
        if (w_s > 5'(BCD_NINE)) begin
          w_digit = 4'(w_s + 5'(BCD_SIX));
          w_c     = 1'b1;
        end else begin
          w_digit = w_s[3:0];
          w_c     = 1'b0;
        end
      end else begin
        // No binary carry out of the digit means a borrow: correct by -6.
        if (w_s < 5'd16) begin
          w_digit = 4'(w_s - 5'(BCD_SIX));
          w_c     = 1'b0;
        end else begin
          w_digit = w_s[3:0];
          w_c     = 1'b1;
        end
      end
      o_result_c[k*4 +: 4] = w_digit;
      if (k == 0) o_hc_c = w_c;
    end
    o_acr_c = w_c;
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequenced, parametrised datapath ALU with registered result/flags.
// Optional feature macro: ALU_SEQ_DECIMAL_EN (decimal adjust second pass).
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_start                   capture operands/selects (ignored while busy)
//   o_busy, o_valid           decimal pass in progress / result updated pulse
//   i_db, i_adl, i_sb         WIDTH-bit source buses
//   i_db_add, i_db_n_add, i_adl_add   B select (priority in that order)
//   i_0_add, i_sb_add         A select (priority in that order)
//   i_1_addc                  carry in
//   i_sums..i_srs             operation selects (priority sums>ands>eors>ors>srs)
//   i_daa, i_dsa              decimal add/subtract adjust (with i_sums)
//   o_add                     adder hold register
//   o_acr, o_avr, o_hc        carry, overflow, half-carry flags
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_valid,
  input  logic [WIDTH-1:0] i_db,
  input  logic             i_db_add,
  input  logic             i_db_n_add,
  input  logic             i_adl_add,
  input  logic [WIDTH-1:0] i_adl,
  input  logic             i_0_add,
  input  logic             i_sb_add,
  input  logic [WIDTH-1:0] i_sb,
  input  logic             i_1_addc,
  input  logic             i_sums,
  input  logic             i_ands,
  input  logic             i_eors,
  input  logic             i_ors,
  input  logic             i_srs,
  input  logic             i_daa,
  input  logic             i_dsa,
  output logic [WIDTH-1:0] o_add,
  output logic             o_acr,
  output logic             o_avr,
  output logic             o_hc
);

  localparam int unsigned SUM_W = WIDTH + 1;
  localparam int unsigned MSB   = WIDTH - 1;

  state_t           r_state;
  logic [WIDTH-1:0] r_add;
  logic             r_acr;
  logic             r_avr;
  logic             r_hc;
  logic             r_valid;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [SUM_W-1:0] w_sum;
  logic             w_sum_avr;
  logic [WIDTH-1:0] w_res;
  logic             w_acr;
  logic             w_avr;
  logic             w_hc;
  logic             w_dec_req;

  // Source muxes; an unselected bus reads as all-ones (precharged).
  always_comb begin
    w_a = '1;
    if (i_0_add)       w_a = '0;
    else if (i_sb_add) w_a = i_sb;
    w_b = '1;
    if (i_db_add)        w_b = i_db;
    else if (i_db_n_add) w_b = ~i_db;
    else if (i_adl_add)  w_b = i_adl;
  end

  assign w_sum     = SUM_W'(w_a) + SUM_W'(w_b) + SUM_W'(i_1_addc);
  assign w_sum_avr = add_overflow(w_a[MSB], w_b[MSB], w_sum[MSB]);

  // Binary/logic result and flags with operation priority.
  always_comb begin
    w_res = '0;
    w_acr = 1'b0;
    w_avr = 1'b0;
    w_hc  = 1'b0;
    if (i_sums) begin
      w_res = w_sum[WIDTH-1:0];
      w_acr = w_sum[WIDTH];
      w_avr = w_sum_avr;
      w_hc  = nibble_carry(w_a[3:0], w_b[3:0], i_1_addc);
    end else if (i_ands) begin
      w_res = w_a & w_b;
    end else if (i_eors) begin
      w_res = w_a ^ w_b;
    end else if (i_ors) begin
      w_res = w_a | w_b;
    end else if (i_srs) begin
      w_res = {1'b0, w_a[WIDTH-1:1]};
      w_acr = w_a[0];
    end
  end

`ifdef ALU_SEQ_DECIMAL_EN
  logic [WIDTH-1:0] r_cap_a;
  logic [WIDTH-1:0] r_cap_b;
  logic             r_cap_cin;
  logic             r_cap_sub;
  logic             r_cap_avr;
  logic             r_busy;
  logic [WIDTH-1:0] w_bcd_res;
  logic             w_bcd_acr;
  logic             w_bcd_hc;

  assign w_dec_req = i_sums & (i_daa | i_dsa);

  alu_seq_bcd_adjust #(
    .WIDTH (WIDTH)
  ) u_bcd_adjust (
    .i_a        (r_cap_a),
    .i_b        (r_cap_b),
    .i_cin      (r_cap_cin),
    .i_sub      (r_cap_sub),
    .o_result_c (w_bcd_res),
    .o_acr_c    (w_bcd_acr),
    .o_hc_c     (w_bcd_hc)
  );

  assign o_busy = r_busy;

  // Capture registers for the decimal pass; overflow is the binary-sum one.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cap_a   <= '0;
      r_cap_b   <= '0;
      r_cap_cin <= 1'b0;
      r_cap_sub <= 1'b0;
      r_cap_avr <= 1'b0;
    end else if (r_state == ST_IDLE && i_start && w_dec_req) begin
      r_cap_a   <= w_a;
      r_cap_b   <= w_b;
      r_cap_cin <= i_1_addc;
      r_cap_sub <= ~i_daa;
      r_cap_avr <= w_sum_avr;
    end
  end
`else
  logic w_unused_dec;
  assign w_unused_dec = i_daa ^ i_dsa;
  assign w_dec_req    = 1'b0;
  assign o_busy       = 1'b0;
`endif

  // Control FSM with registered result, flags and handshake.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_add   <= '0;
      r_acr   <= 1'b0;
      r_avr   <= 1'b0;
      r_hc    <= 1'b0;
      r_valid <= 1'b0;
`ifdef ALU_SEQ_DECIMAL_EN
      r_busy  <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            if (w_dec_req) begin
              r_state <= ST_ADJ;
`ifdef ALU_SEQ_DECIMAL_EN
              r_busy  <= 1'b1;
`endif
            end else begin
              r_add   <= w_res;
              r_acr   <= w_acr;
              r_avr   <= w_avr;
              r_hc    <= w_hc;
              r_valid <= 1'b1;
            end
          end
        end
        ST_ADJ: begin
          r_state <= ST_IDLE;
`ifdef ALU_SEQ_DECIMAL_EN
          r_busy  <= 1'b0;
          r_add   <= w_bcd_res;
          r_acr   <= w_bcd_acr;
          r_avr   <= r_cap_avr;
          r_hc    <= w_bcd_hc;
          r_valid <= 1'b1;
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_add   = r_add;
  assign o_acr   = r_acr;
  assign o_avr   = r_avr;
  assign o_hc    = r_hc;
  assign o_valid = r_valid;

endmodule
